// File: rtl/decode_hazard_unit_pkg.sv
// Shared parameters and FSM encoding for the decode hazard unit.
package decode_hazard_unit_pkg;

    localparam int HZ_RIW         = 5;
    localparam int HZ_NUM_REGS    = 32;
    localparam int HZ_MUL_LATENCY = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_USE = 2'd1,
        MEM_WAIT = 2'd2,
        MUL_BUSY = 2'd3
    } hazard_state_e;

    // Width of a counter that must hold values 0..lat.
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/decode_hazard_unit_scoreboard.sv
// Load scoreboard: one pending bit per architectural register, two async read ports.
module hazard_scoreboard
    import decode_hazard_unit_pkg::*;
#(
    parameter int REGISTER_INDEX_WIDTH = HZ_RIW,
    parameter int NUM_REGISTERS        = HZ_NUM_REGS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            set_en_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] set_address_in,
    input  logic                            clr_en_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] clr_address_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] rd1_address_in,
    output logic                            rd1_pending_out,
    input  logic [REGISTER_INDEX_WIDTH-1:0] rd2_address_in,
    output logic                            rd2_pending_out
);

    logic [NUM_REGISTERS-1:0] pending_q, pending_d;

    // Clear first so a set to the same index on the same edge wins; r0 never becomes pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_in)
            pending_d[clr_address_in] = 1'b0;
        if (set_en_in && (set_address_in != '0))
            pending_d[set_address_in] = 1'b1;
    end

    // Pending bit register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending_q <= '0;
        else          pending_q <= pending_d;
    end

    assign rd1_pending_out = pending_q[rd1_address_in];
    assign rd2_pending_out = pending_q[rd2_address_in];

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode hazard unit: stalls/bubbles the front-end pipeline registers for load-use,
// multi-cycle MUL occupancy and data-cache busy. Outputs are combinational from
// state and inputs so they settle before the decode registers capture on negedge.
module decode_hazard_unit
    import decode_hazard_unit_pkg::*;
#(
    parameter int REGISTER_INDEX_WIDTH = HZ_RIW,
    parameter int NUM_REGISTERS        = HZ_NUM_REGS,
    parameter int MUL_LATENCY          = HZ_MUL_LATENCY
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [REGISTER_INDEX_WIDTH-1:0] id_src1_address_in,
    input  logic                            id_src1_used_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] id_src2_address_in,
    input  logic                            id_src2_used_in,
    input  logic                            id_is_mul_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] ex_dst_address_in,
    input  logic                            ex_mem_read_in,
    input  logic                            ex_reg_write_in,
    input  logic                            wb_valid_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] wb_address_in,
    input  logic                            mem_busy_in,
    output logic                            stall_out,
    output logic                            bubble_out,
    output logic                            mul_busy_out,
    output logic [1:0]                      state_out
);

    localparam int CNT_W = cnt_width(MUL_LATENCY);

    hazard_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall, bubble;
    logic             ex_load, src1_pending, src2_pending, hazard;

    assign ex_load = ex_mem_read_in & ex_reg_write_in;

    // A load advances into MEM (and becomes pending) on any edge the cache is not busy.
    hazard_scoreboard #(
        .REGISTER_INDEX_WIDTH (REGISTER_INDEX_WIDTH),
        .NUM_REGISTERS        (NUM_REGISTERS)
    ) u_scoreboard (
        .clk             (clk),
        .reset_n         (reset_n),
        .set_en_in       (ex_load & ~mem_busy_in),
        .set_address_in  (ex_dst_address_in),
        .clr_en_in       (wb_valid_in),
        .clr_address_in  (wb_address_in),
        .rd1_address_in  (id_src1_address_in),
        .rd1_pending_out (src1_pending),
        .rd2_address_in  (id_src2_address_in),
        .rd2_pending_out (src2_pending)
    );

    assign hazard =
        (id_src1_used_in && (id_src1_address_in != '0) &&
         (src1_pending || (ex_load && (ex_dst_address_in == id_src1_address_in)))) ||
        (id_src2_used_in && (id_src2_address_in != '0) &&
         (src2_pending || (ex_load && (ex_dst_address_in == id_src2_address_in))));

    // Next state and Mealy outputs; priority mem_busy > MUL occupancy > hazard > new MUL.
    // A MUL interrupted by a cache miss keeps its count in MEM_WAIT and resumes when the
    // cache frees up, so EX is never released early.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        if (mem_busy_in) begin
            stall   = 1'b1;
            state_d = MEM_WAIT;
        end else if ((state_q == MUL_BUSY) || ((state_q == MEM_WAIT) && (cnt_q != '0))) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = MUL_BUSY;
                cnt_d   = cnt_q - CNT_W'(1);
            end
        end else if (state_q == MEM_WAIT) begin
            // Hold one more cycle; hazards are looked at afresh once back in IDLE.
            stall   = 1'b1;
            state_d = IDLE;
        end else if (hazard) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = LOAD_USE;
        end else begin
            // No hazard: the decoded instruction issues. A MUL leaving LOAD_USE is
            // tracked exactly like one issued from IDLE.
            state_d = IDLE;
            if (id_is_mul_in && (MUL_LATENCY > 1)) begin
                state_d = MUL_BUSY;
                cnt_d   = CNT_W'(MUL_LATENCY - 1);
            end
        end
    end

    // State and MUL counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs forced low while reset is held, independent of live inputs.
    assign stall_out    = reset_n & stall;
    assign bubble_out   = reset_n & bubble;
    assign mul_busy_out = reset_n & (cnt_q != '0);
    assign state_out    = state_q;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Self-checking bench for decode_hazard_unit: directed scenarios plus random stimulus
// against a cycle-level reference model of the hazard rules.
module tb_decode_hazard_unit;

    localparam int L = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] s1, s2, exd, wba;
    logic       s1u, s2u, mul, exr, exw, wbv, mb;
    logic       stall, bubble, mbusy;
    logic [1:0] st;

    always #5 clk = ~clk;

    decode_hazard_unit dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .id_src1_address_in (s1),
        .id_src1_used_in    (s1u),
        .id_src2_address_in (s2),
        .id_src2_used_in    (s2u),
        .id_is_mul_in       (mul),
        .ex_dst_address_in  (exd),
        .ex_mem_read_in     (exr),
        .ex_reg_write_in    (exw),
        .wb_valid_in        (wbv),
        .wb_address_in      (wba),
        .mem_busy_in        (mb),
        .stall_out          (stall),
        .bubble_out         (bubble),
        .mul_busy_out       (mbusy),
        .state_out          (st)
    );

    int    total = 0;
    int    bad   = 0;
    string ph    = "init";

    // Reference model: pending registers, remaining MUL stall cycles, cache-hold flag.
    bit pend[32];
    int mul_left;
    bit mem_hold;
    int exp_state;
    logic obs_stall, obs_bub;
    logic [1:0] obs_st;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%0d exp=%0d", ph, tag, got, exp);
        end
    endtask

    function automatic bit src_haz(input logic [4:0] a, input logic u);
        return u && (a != '0) && (pend[a] || (exr && exw && (exd == a)));
    endfunction

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        mul_left  = 0;
        mem_hold  = 1'b0;
        exp_state = 0;
    endtask

    task automatic model_edge();
        bit h, lu;
        h  = src_haz(s1, s1u) || src_haz(s2, s2u);
        lu = 1'b0;
        if (mb) mem_hold = 1'b1;
        else if (mul_left > 0) begin mul_left--; mem_hold = 1'b0; end
        else if (mem_hold) mem_hold = 1'b0;
        else if (h) lu = 1'b1;
        else if (mul) mul_left = L - 1;
        if (wbv) pend[wba] = 1'b0;
        if (!mb && exr && exw && (exd != '0)) pend[exd] = 1'b1;
        exp_state = mem_hold ? 2 : (mul_left > 0) ? 3 : lu ? 1 : 0;
    endtask

    // Inputs are set at posedge+1; outputs are sampled at negedge, model advances at posedge.
    task automatic step();
        bit es, eb, h;
        @(negedge clk);
        h = src_haz(s1, s1u) || src_haz(s2, s2u);
        if (mb)                begin es = 1; eb = 0; end
        else if (mul_left > 0) begin es = 1; eb = 1; end
        else if (mem_hold)     begin es = 1; eb = 0; end
        else if (h)            begin es = 1; eb = 1; end
        else                   begin es = 0; eb = 0; end
        obs_stall = stall; obs_bub = bubble; obs_st = st;
        chk("stall",    32'(stall),  32'(es));
        chk("bubble",   32'(bubble), 32'(eb));
        chk("mul_busy", 32'(mbusy),  32'(mul_left > 0));
        chk("state",    32'(st),     32'(exp_state));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clr();
        s1 = '0; s2 = '0; exd = '0; wba = '0;
        s1u = 0; s2u = 0; mul = 0; exr = 0; exw = 0; wbv = 0; mb = 0;
    endtask

    initial begin
        model_reset();
        clr();
        // Reset with live hazard and cache-busy inputs: outputs must still be 0.
        ph = "reset";
        mb = 1; exr = 1; exw = 1; exd = 5; s1 = 5; s1u = 1;
        #12;
        chk("stall", 32'(stall), 0);
        chk("bubble", 32'(bubble), 0);
        chk("mul_busy", 32'(mbusy), 0);
        chk("state", 32'(st), 0);
        clr();
        @(posedge clk); #1 reset_n = 1'b1;

        // Load-use on r5, then writeback clears it.
        ph = "lu";
        clr(); exr = 1; exw = 1; exd = 5; s1 = 5; s1u = 1;
        step(); chk("stall_ex", 32'(obs_stall), 1); chk("bubble_ex", 32'(obs_bub), 1);
        clr(); s1 = 5; s1u = 1; wbv = 1; wba = 5;
        step(); chk("stall_pend", 32'(obs_stall), 1); chk("state_lu", 32'(obs_st), 1);
        clr(); s1 = 5; s1u = 1;
        step(); chk("stall_clear", 32'(obs_stall), 0);
        clr(); step();

        // MUL: issue cycle free, then L-1 stall cycles, then idle.
        ph = "mul";
        clr(); mul = 1;
        step(); chk("issue_stall", 32'(obs_stall), 0);
        clr();
        for (int i = 0; i < L - 1; i++) begin
            step(); chk("busy_stall", 32'(obs_stall), 1); chk("busy_bubble", 32'(obs_bub), 1);
        end
        step(); chk("done_stall", 32'(obs_stall), 0); chk("done_state", 32'(obs_st), 0);

        // Cache busy for 3 cycles while the MUL counter is 2.
        ph = "mw";
        clr(); mul = 1; step(); clr(); step(); step();
        mb = 1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("mb_stall", 32'(obs_stall), 1); chk("mb_bubble", 32'(obs_bub), 0);
        end
        mb = 0;
        for (int i = 0; i < 2; i++) begin
            step(); chk("resume_stall", 32'(obs_stall), 1); chk("resume_bubble", 32'(obs_bub), 1);
        end
        step(); chk("after_stall", 32'(obs_stall), 0);

        // r0 never hazards and never becomes pending.
        ph = "r0";
        clr(); exr = 1; exw = 1; exd = 0; s1u = 1; s2u = 1;
        step(); chk("ex_stall", 32'(obs_stall), 0);
        clr(); s1u = 1;
        step(); chk("pend_stall", 32'(obs_stall), 0);

        // Load to r7 with a same-edge writeback of r7: set wins.
        ph = "r7";
        clr(); exr = 1; exw = 1; exd = 7; wbv = 1; wba = 7;
        step(); chk("set_stall", 32'(obs_stall), 0);
        clr(); s2 = 7; s2u = 1;
        step(); chk("pend_stall", 32'(obs_stall), 1);
        clr(); wbv = 1; wba = 7; step();
        clr(); step();

        // Asynchronous reset in the middle of MUL_BUSY with counter 3.
        ph = "rst";
        clr(); mul = 1; step(); clr(); step();
        chk("pre_stall", 32'(stall), 1);
        chk("pre_mul_busy", 32'(mbusy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("stall", 32'(stall), 0);
        chk("bubble", 32'(bubble), 0);
        chk("mul_busy", 32'(mbusy), 0);
        chk("state", 32'(st), 0);
        model_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        step(); chk("post_stall", 32'(obs_stall), 0);

        // Random traffic over a small register window so hazards are frequent.
        ph = "rand";
        for (int n = 0; n < 3000; n++) begin
            s1  = 5'($urandom_range(0, 7));
            s2  = 5'($urandom_range(0, 7));
            s1u = 1'($urandom_range(0, 1));
            s2u = 1'($urandom_range(0, 1));
            exd = 5'($urandom_range(0, 7));
            exr = ($urandom_range(0, 2) == 0);
            exw = ($urandom_range(0, 3) != 0);
            wbv = ($urandom_range(0, 2) == 0);
            wba = 5'($urandom_range(0, 7));
            mb  = ($urandom_range(0, 9) == 0);
            mul = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
